// File: rtl/mux_nch_scan.sv
// -----------------------------------------------------------------------------
// mux_nch_scan
//
// N-channel, W-bit multiplexer with a registered output and two selection
// modes:
//   - manual: a channel select is loaded with a one-cycle strobe;
//   - scan:   an internal pointer steps through every channel, holding each
//             one for DWELL cycles.
// Every output word is tagged with the index of the channel that produced it.
//
// Optional feature (macro MUX_NCH_CH_MASK_EN): adds a per-channel enable mask.
// Scan skips masked channels, and a manual load of a masked channel is
// rejected. With the macro undefined all channels are enabled.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   i_data    in   packed channel inputs, channel k = i_data[k*W +: W]
//   en        in   block enable (0 = idle)
//   mode      in   0 = manual, 1 = scan
//   sel       in   manual channel select
//   sel_load  in   one-cycle strobe capturing sel in manual mode
//   ch_mask   in   per-channel enable, only with MUX_NCH_CH_MASK_EN
//   y         out  registered selected data
//   y_ch      out  channel index that produced y
//   y_valid   out  y / y_ch valid this cycle
//   wrap      out  pulse on the cycle y_ch first shows the channel reached
//                  by a wrap-around advance
//   sel_err   out  pulse after a rejected manual select
// -----------------------------------------------------------------------------
module mux_nch_scan #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2,
    parameter int DWELL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   i_data,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_load,
`ifdef MUX_NCH_CH_MASK_EN
    input  logic [N_CH-1:0]     ch_mask,
`endif
    output logic [W-1:0]        y,
    output logic [SEL_W-1:0]    y_ch,
    output logic                y_valid,
    output logic                wrap,
    output logic                sel_err
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      y_q, y_d;
    logic [SEL_W-1:0]  y_ch_q, y_ch_d;
    logic              y_valid_q, y_valid_d;
    logic              wrap_q, wrap_d;
    logic              sel_err_q, sel_err_d;
    logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
    logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    // Set on the last dwell cycle: the next scan cycle outputs the following
    // channel, so cur_ch always names the channel currently shown on y.
    logic              adv_q, adv_d;

    logic [W-1:0]      ch_data [N_CH];
    logic [N_CH-1:0]   ch_en;
    logic [SEL_W-1:0]  ch_next;
    logic [W-1:0]      sel_data;
    logic              sel_ok;
    logic [DW_W-1:0]   dwell_eff;

    // Next-enabled-channel search results
    logic              hi_found, lo_found, any_en;
    logic [SEL_W-1:0]  hi_ch, lo_ch, adv_ch;
    logic              adv_wrap;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_split
            assign ch_data[gi] = i_data[gi*W +: W];
        end
    endgenerate

`ifdef MUX_NCH_CH_MASK_EN
    assign ch_en = ch_mask;
`else
    assign ch_en = '1;
`endif

    // Next enabled channel after cur_ch in ascending modulo order. Scanning
    // downwards leaves the lowest qualifying index in each bucket: hi_* is
    // the first enabled channel above cur_ch, lo_* the first at or below it
    // (reaching it means the advance went through index 0).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_ch    = cur_ch_q;
        lo_ch    = cur_ch_q;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (ch_en[j]) begin
                if (SEL_W'(j) > cur_ch_q) begin
                    hi_found = 1'b1;
                    hi_ch    = SEL_W'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_ch    = SEL_W'(j);
                end
            end
        end
        any_en   = hi_found | lo_found;
        adv_ch   = hi_found ? hi_ch : lo_ch;
        adv_wrap = ~hi_found & lo_found;
    end

    // A manual select is accepted only if it names an existing, enabled channel.
    always_comb begin
        sel_ok = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            if (sel == SEL_W'(j) && ch_en[j]) begin
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (ch_next == SEL_W'(j)) begin
                sel_data = ch_data[j];
            end
        end
    end

    // Dwell always restarts from zero when scan is (re)entered.
    assign dwell_eff = (state_q == SCAN) ? dwell_cnt_q : '0;

    always_comb begin
        state_d     = !en ? IDLE : (mode ? SCAN : MAN);
        y_d         = y_q;
        y_ch_d      = y_ch_q;
        y_valid_d   = 1'b0;
        wrap_d      = 1'b0;
        sel_err_d   = 1'b0;
        cur_ch_d    = cur_ch_q;
        dwell_cnt_d = dwell_cnt_q;
        adv_d       = 1'b0;
        ch_next     = cur_ch_q;

        case (state_d)
            IDLE: begin
                dwell_cnt_d = '0;
            end
            MAN: begin
                dwell_cnt_d = '0;
                if (sel_load) begin
                    if (sel_ok) begin
                        ch_next = sel;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                cur_ch_d  = ch_next;
                y_d       = sel_data;
                y_ch_d    = ch_next;
                y_valid_d = 1'b1;
            end
            SCAN: begin
                if (any_en) begin
                    if (adv_q) begin
                        ch_next = adv_ch;
                        wrap_d  = adv_wrap;
                    end
                    cur_ch_d = ch_next;
                    if (dwell_eff == DWELL_LAST) begin
                        dwell_cnt_d = '0;
                        adv_d       = 1'b1;
                    end else begin
                        dwell_cnt_d = dwell_eff + 1'b1;
                    end
                    y_d       = sel_data;
                    y_ch_d    = ch_next;
                    y_valid_d = 1'b1;
                end else begin
                    // Nothing enabled: freeze the scan where it is.
                    adv_d = adv_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            y_ch_q      <= '0;
            y_valid_q   <= 1'b0;
            wrap_q      <= 1'b0;
            sel_err_q   <= 1'b0;
            cur_ch_q    <= '0;
            dwell_cnt_q <= '0;
            adv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_ch_q      <= y_ch_d;
            y_valid_q   <= y_valid_d;
            wrap_q      <= wrap_d;
            sel_err_q   <= sel_err_d;
            cur_ch_q    <= cur_ch_d;
            dwell_cnt_q <= dwell_cnt_d;
            adv_q       <= adv_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign wrap    = wrap_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_nch_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_nch_scan
//
// Three instances share the control inputs:
//   dut4 : N_CH=4, DWELL=1   (manual load, scan, mode priority, reset)
//   dut3 : N_CH=3, DWELL=1   (invalid select, non-power-of-2 scan)
//   dutd : N_CH=4, DWELL=3   (dwell hold and en drop mid-dwell)
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_mux_nch_scan;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, sel_load;
    logic [1:0]  sel;
    logic [31:0] d4;
    logic [23:0] d3;

    logic [7:0]  y4, y3, yd;
    logic [1:0]  ych4, ych3, ychd;
    logic        v4, v3, vd, w4, w3, wd, e4, e3, ed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_nch_scan #(.N_CH(4), .W(8), .SEL_W(2), .DWELL(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_data(d4), .en(en), .mode(mode),
        .sel(sel), .sel_load(sel_load), .y(y4), .y_ch(ych4),
        .y_valid(v4), .wrap(w4), .sel_err(e4));

    mux_nch_scan #(.N_CH(3), .W(8), .SEL_W(2), .DWELL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_data(d3), .en(en), .mode(mode),
        .sel(sel), .sel_load(sel_load), .y(y3), .y_ch(ych3),
        .y_valid(v3), .wrap(w3), .sel_err(e3));

    mux_nch_scan #(.N_CH(4), .W(8), .SEL_W(2), .DWELL(3)) dutd (
        .clk(clk), .rst_n(rst_n), .i_data(d4), .en(en), .mode(mode),
        .sel(sel), .sel_load(sel_load), .y(yd), .y_ch(ychd),
        .y_valid(vd), .wrap(wd), .sel_err(ed));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 2'd0; sel_load = 1'b0;
        d4 = 32'h44332211; d3 = 24'h332211;
        repeat (2) tick();
        n_checks++; if (y4 !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", y4); end
        n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", v4); end
        n_checks++; if (ych4 !== 2'd0) begin n_fail++; $display("FAIL reset_ych: got %0d want 0", ych4); end
        n_checks++; if ({w4, e4, w3, e3, wd, ed} !== 6'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 000000", {w4, e4, w3, e3, wd, ed}); end
        $display("reset: y=%h y_ch=%0d y_valid=%b", y4, ych4, v4);
        rst_n = 1'b1;
    endtask

    task automatic test_manual_load();
        en = 1'b1; mode = 1'b0; sel = 2'd2; sel_load = 1'b1;
        tick();
        n_checks++; if (y4 !== 8'h33) begin n_fail++; $display("FAIL load_y: got %h want 33", y4); end
        n_checks++; if (ych4 !== 2'd2) begin n_fail++; $display("FAIL load_ych: got %0d want 2", ych4); end
        n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b want 1", v4); end
        $display("load sel=2: y=%h y_ch=%0d y_valid=%b", y4, ych4, v4);
        sel_load = 1'b0; sel = 2'd0; d4 = 32'h44AA2211;
        tick();
        n_checks++; if (y4 !== 8'hAA || ych4 !== 2'd2) begin n_fail++; $display("FAIL load_track: got y=%h ch=%0d want y=aa ch=2", y4, ych4); end
        $display("data change on ch2: y=%h y_ch=%0d", y4, ych4);
        d4 = 32'h44332211;
    endtask

    task automatic test_invalid_select();
        en = 1'b1; mode = 1'b0; sel = 2'd1; sel_load = 1'b1;
        tick();
        n_checks++; if (ych3 !== 2'd1 || e3 !== 1'b0) begin n_fail++; $display("FAIL inv_pre: got ch=%0d err=%b want ch=1 err=0", ych3, e3); end
        sel = 2'd3;
        tick();
        n_checks++; if (e3 !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b want 1", e3); end
        n_checks++; if (ych3 !== 2'd1 || y3 !== 8'h22) begin n_fail++; $display("FAIL inv_hold: got ch=%0d y=%h want ch=1 y=22", ych3, y3); end
        n_checks++; if (e4 !== 1'b0 || ych4 !== 2'd3) begin n_fail++; $display("FAIL inv_n4_ok: got err=%b ch=%0d want err=0 ch=3", e4, ych4); end
        $display("sel=3 on N_CH=3: sel_err=%b y_ch=%0d", e3, ych3);
        sel_load = 1'b0;
        tick();
        n_checks++; if (e3 !== 1'b0 || ych3 !== 2'd1) begin n_fail++; $display("FAIL inv_pulse: got err=%b ch=%0d want err=0 ch=1", e3, ych3); end
        en = 1'b0; sel_load = 1'b1;
        tick();
        n_checks++; if (e3 !== 1'b0 || v3 !== 1'b0 || ych3 !== 2'd1) begin n_fail++; $display("FAIL inv_idle: got err=%b v=%b ch=%0d want 0 0 1", e3, v3, ych3); end
        $display("sel_load while idle: sel_err=%b y_valid=%b", e3, v3);
        sel_load = 1'b0; en = 1'b1;
    endtask

    task automatic test_scan_dwell1();
        logic [1:0] exp4 [6];
        logic [1:0] exp3 [6];
        exp4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        en = 1'b1; mode = 1'b0; sel = 2'd0; sel_load = 1'b1;
        tick();
        n_checks++; if (ych4 !== 2'd0 || ych3 !== 2'd0) begin n_fail++; $display("FAIL scan_start: got %0d/%0d want 0/0", ych4, ych3); end
        sel_load = 1'b0; mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (ych4 !== exp4[i] || y4 !== 8'h11 * (exp4[i] + 8'd1) || v4 !== 1'b1)
                begin n_fail++; $display("FAIL scan4_%0d: got ch=%0d y=%h v=%b want ch=%0d", i, ych4, y4, v4, exp4[i]); end
            n_checks++; if (w4 !== (i == 4)) begin n_fail++; $display("FAIL wrap4_%0d: got %b want %b", i, w4, (i == 4)); end
            n_checks++; if (ych3 !== exp3[i] || w3 !== (i == 3))
                begin n_fail++; $display("FAIL scan3_%0d: got ch=%0d wrap=%b want ch=%0d wrap=%b", i, ych3, w3, exp3[i], (i == 3)); end
            $display("scan step %0d: n4 ch=%0d y=%h wrap=%b | n3 ch=%0d wrap=%b", i, ych4, y4, w4, ych3, w3);
        end
    endtask

    task automatic test_scan_dwell3();
        en = 1'b1; mode = 1'b0; sel = 2'd0; sel_load = 1'b1;
        tick();
        sel_load = 1'b0; mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (ychd !== 2'd0 || yd !== 8'h11 || vd !== 1'b1) begin n_fail++; $display("FAIL dwell_ch0_%0d: got ch=%0d y=%h v=%b want 0 11 1", i, ychd, yd, vd); end
            $display("dwell3 cycle %0d: y_ch=%0d y=%h", i, ychd, yd);
        end
        repeat (2) begin
            tick();
            n_checks++; if (ychd !== 2'd1 || yd !== 8'h22) begin n_fail++; $display("FAIL dwell_ch1: got ch=%0d y=%h want 1 22", ychd, yd); end
        end
        en = 1'b0; d4 = 32'hDEADBEEF;
        tick();
        n_checks++; if (vd !== 1'b0 || yd !== 8'h22 || ychd !== 2'd1 || wd !== 1'b0) begin n_fail++; $display("FAIL dwell_idle: got v=%b y=%h ch=%0d wrap=%b want 0 22 1 0", vd, yd, ychd, wd); end
        $display("en dropped: y_valid=%b y=%h y_ch=%0d", vd, yd, ychd);
        d4 = 32'h44332211; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (ychd !== 2'd1 || vd !== 1'b1) begin n_fail++; $display("FAIL dwell_resume_%0d: got ch=%0d v=%b want 1 1", i, ychd, vd); end
            $display("resume cycle %0d: y_ch=%0d", i, ychd);
        end
        tick();
        n_checks++; if (ychd !== 2'd2 || yd !== 8'h33) begin n_fail++; $display("FAIL dwell_next: got ch=%0d y=%h want 2 33", ychd, yd); end
    endtask

    task automatic test_mode_priority();
        logic [1:0] exp [3];
        exp = '{2'd2, 2'd3, 2'd0};
        en = 1'b1; mode = 1'b0; sel = 2'd1; sel_load = 1'b1;
        tick();
        n_checks++; if (ych4 !== 2'd1) begin n_fail++; $display("FAIL prio_load: got %0d want 1", ych4); end
        mode = 1'b1; sel = 2'd3; sel_load = 1'b1;
        tick();
        n_checks++; if (ych4 !== 2'd1 || e4 !== 1'b0) begin n_fail++; $display("FAIL prio_ignore: got ch=%0d err=%b want 1 0", ych4, e4); end
        sel_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (ych4 !== exp[i] || w4 !== (i == 2)) begin n_fail++; $display("FAIL prio_scan_%0d: got ch=%0d wrap=%b want %0d %b", i, ych4, w4, exp[i], (i == 2)); end
            $display("priority scan %0d: y_ch=%0d wrap=%b", i, ych4, w4);
        end
        mode = 1'b0;
        repeat (2) begin
            tick();
            n_checks++; if (ych4 !== 2'd0 || y4 !== 8'h11 || v4 !== 1'b1 || w4 !== 1'b0) begin n_fail++; $display("FAIL prio_back_man: got ch=%0d y=%h v=%b wrap=%b want 0 11 1 0", ych4, y4, v4, w4); end
            $display("back to manual: y_ch=%0d y=%h", ych4, y4);
        end
    endtask

    task automatic test_reset_midscan();
        en = 1'b1; mode = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if (v4 !== 1'b0 || ych4 !== 2'd0 || y4 !== 8'h00 || w4 !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got v=%b ch=%0d y=%h wrap=%b want 0 0 00 0", v4, ych4, y4, w4); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (ych4 !== 2'd0 || y4 !== 8'h11 || v4 !== 1'b1) begin n_fail++; $display("FAIL rst_restart: got ch=%0d y=%h v=%b want 0 11 1", ych4, y4, v4); end
        $display("restart after reset: y_ch=%0d y=%h", ych4, y4);
    endtask

    initial begin
        test_reset();
        test_manual_load();
        test_invalid_select();
        test_scan_dwell1();
        test_scan_dwell3();
        test_mode_priority();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
